// File: rtl/eth_fifo_pkg.sv
// rtl/eth_fifo_pkg.sv - shared types and sizes for the async FIFO write path
package eth_fifo_pkg;

    localparam int CNT_W      = 12;
    localparam int FIFO_DEPTH = 4096;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        XFER  = 3'd2,
        DRAIN = 3'd3,
        GAP   = 3'd4
    } afifo_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching from the index after last_idx
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_mask,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last_idx) + k) % N);
            if (!found && req_mask[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/afifo_wr_frame_arbiter.sv
// rtl/afifo_wr_frame_arbiter.sv - frame-level round-robin arbiter on the async FIFO write port
module afifo_wr_frame_arbiter #(
    parameter int N_SRC      = 2,
    parameter int FIFO_DEPTH = eth_fifo_pkg::FIFO_DEPTH,
    parameter int CNT_W      = eth_fifo_pkg::CNT_W,
    parameter int MARGIN     = 8,
    parameter int GAP_CYC    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         req_i,
    input  logic [N_SRC*CNT_W-1:0]   req_len_i,
    input  logic [N_SRC*8-1:0]       src_data_i,
    input  logic [N_SRC-1:0]         src_valid_i,
    input  logic [N_SRC-1:0]         src_last_i,
    output logic [N_SRC-1:0]         src_ready_o,
    output logic [N_SRC-1:0]         grant_o,
    output logic [7:0]               fifo_din_o,
    output logic                     fifo_wr_en_o,
    input  logic                     fifo_full_i,
    input  logic [CNT_W-1:0]         fifo_wr_data_count_i,
    output logic                     err_len_o,
    output logic                     busy_o
);

    import eth_fifo_pkg::*;

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [CNT_W:0] DEPTH_M1 = (CNT_W+1)'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0] MARGIN_W = (CNT_W+1)'(MARGIN);

    afifo_arb_state_t state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] g_idx_q, g_idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W:0]   len_q, len_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       din_q, din_d;
    logic             wr_en_q, wr_en_d;
    logic             err_q, err_d;
    logic             zseen_q, zseen_d;

    logic [CNT_W:0]   free, room, cnt_inc;
    logic [CNT_W:0]   len_arr [N_SRC];
    logic [7:0]       data_arr [N_SRC];
    logic [N_SRC-1:0] elig, zlen, pick;
    logic [IDX_W-1:0] pick_idx;
    logic             hs;

    // free-MARGIN saturates so a nearly full FIFO never wraps into a huge budget
    always_comb begin
        free     = DEPTH_M1 - {1'b0, fifo_wr_data_count_i};
        room     = (free >= MARGIN_W) ? (free - MARGIN_W) : '0;
        elig     = '0;
        zlen     = '0;
        pick_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            len_arr[i]  = {1'b0, req_len_i[i*CNT_W +: CNT_W]};
            data_arr[i] = src_data_i[i*8 +: 8];
            zlen[i]     = req_i[i] && (len_arr[i] == '0);
            elig[i]     = req_i[i] && (len_arr[i] != '0) && (len_arr[i] <= room);
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req_mask (elig),
        .last_idx (last_q),
        .gnt      (pick)
    );

    always_comb begin
        src_ready_o = '0;
        if (state_q == XFER && !fifo_full_i) begin
            src_ready_o = grant_q;
        end else if (state_q == DRAIN) begin
            src_ready_o = grant_q;
        end
    end

    assign hs      = src_valid_i[g_idx_q] && src_ready_o[g_idx_q];
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        g_idx_d = g_idx_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        din_d   = din_q;
        wr_en_d = 1'b0;
        err_d   = 1'b0;
        zseen_d = zseen_q;
        case (state_q)
            IDLE: begin
                zseen_d = 1'b0;
                if (|req_i) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                // a zero-length request is reported once per arbitration visit, not every cycle
                if (|zlen && !zseen_q) begin
                    err_d   = 1'b1;
                    zseen_d = 1'b1;
                end
                if (|pick) begin
                    grant_d = pick;
                    g_idx_d = pick_idx;
                    len_d   = len_arr[pick_idx];
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (hs) begin
                    din_d   = data_arr[g_idx_q];
                    wr_en_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if (src_last_i[g_idx_q]) begin
                        err_d   = (cnt_inc != len_q);
                        state_d = GAP;
                    end else if (cnt_inc == len_q) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (src_valid_i[g_idx_q] && src_last_i[g_idx_q]) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GAP && state_q != GAP) begin
            grant_d = '0;
            gap_d   = '0;
            last_d  = g_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            g_idx_q <= '0;
            last_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            din_q   <= 8'h00;
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            zseen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            g_idx_q <= g_idx_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            din_q   <= din_d;
            wr_en_q <= wr_en_d;
            err_q   <= err_d;
            zseen_q <= zseen_d;
        end
    end

    assign grant_o      = grant_q;
    assign fifo_din_o   = din_q;
    assign fifo_wr_en_o = wr_en_q;
    assign err_len_o    = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_afifo_wr_frame_arbiter.sv
// tb/tb_afifo_wr_frame_arbiter.sv - directed self-checking bench for the frame write arbiter
module tb_afifo_wr_frame_arbiter;

    localparam int N_SRC = 2;
    localparam int CNT_W = 12;

    logic                   clk;
    logic                   rst_n;
    logic [N_SRC-1:0]       req;
    logic [N_SRC*CNT_W-1:0] req_len;
    logic [N_SRC*8-1:0]     src_data;
    logic [N_SRC-1:0]       src_valid;
    logic [N_SRC-1:0]       src_last;
    logic [N_SRC-1:0]       src_ready;
    logic [N_SRC-1:0]       grant;
    logic [7:0]             fifo_din;
    logic                   fifo_wr_en;
    logic                   fifo_full;
    logic [CNT_W-1:0]       wr_count;
    logic                   err_len;
    logic                   busy;

    int passed = 0;
    int total  = 0;
    int err_cnt = 0;
    logic [7:0] wr_q[$];
    logic [7:0] exp_q[$];

    afifo_wr_frame_arbiter #(
        .N_SRC(N_SRC), .FIFO_DEPTH(4096), .CNT_W(CNT_W), .MARGIN(8), .GAP_CYC(2)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_i                (req),
        .req_len_i            (req_len),
        .src_data_i           (src_data),
        .src_valid_i          (src_valid),
        .src_last_i           (src_last),
        .src_ready_o          (src_ready),
        .grant_o              (grant),
        .fifo_din_o           (fifo_din),
        .fifo_wr_en_o         (fifo_wr_en),
        .fifo_full_i          (fifo_full),
        .fifo_wr_data_count_i (wr_count),
        .err_len_o            (err_len),
        .busy_o               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) wr_q.push_back(fifo_din);
        if (err_len === 1'b1) err_cnt++;
    end

    function automatic logic [7:0] dval(input int s, input int i);
        return (s == 0) ? 8'(i) : (8'h80 | 8'(i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int s);
        int n = 0;
        while (grant === '0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("grant", 32'(grant), 32'(1 << s));
        req[s] = 1'b0;
    endtask

    task automatic send_bytes(input int s, input int len, input int n_total,
                              input int last_pos, input int fp);
        int i = 0;
        int c = 0;
        while (i < n_total && c < 500) begin
            @(negedge clk);
            if (fp > 0) fifo_full = ((c / fp) % 2) == 1;
            src_data[s*8 +: 8] = dval(s, i);
            src_valid[s] = 1'b1;
            src_last[s]  = (i + 1 == last_pos);
            #1;
            if (fp > 0) chk("ready_mirror", 32'(src_ready[s]), 32'(!fifo_full));
            if (src_ready[s] === 1'b1) begin
                if (i < len) exp_q.push_back(dval(s, i));
                i++;
            end
            c++;
        end
        if (i < n_total) chk("send_timeout", i, n_total);
        @(negedge clk);
        src_valid[s] = 1'b0;
        src_last[s]  = 1'b0;
        fifo_full    = 1'b0;
    endtask

    task automatic check_frames(input int exp_err);
        int n = 0;
        int bad = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 0);
        @(posedge clk); #1;
        chk("wr_count", wr_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            if (wr_q[k] !== exp_q[k]) bad++;
        end
        chk("wr_order", bad, 0);
        chk("err_count", err_cnt, exp_err);
        wr_q.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_len = '0; src_data = '0; src_valid = '0;
        src_last = '0; fifo_full = 1'b0; wr_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ready", 32'(src_ready), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_din", 32'(fifo_din), 0);
        chk("rst_err_busy", 32'({err_len, busy}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single 64-byte frame from src0, then a 2-cycle gap
        req_len[0 +: CNT_W] = 12'd64; req[0] = 1'b1;
        wait_grant(0);
        send_bytes(0, 64, 64, 64, 0);
        chk("gap1_grant", 32'(grant), 0);
        chk("gap1_busy", 32'(busy), 1);
        chk("gap1_last_wr", 32'(fifo_wr_en), 1);
        @(negedge clk);
        chk("gap2_busy", 32'(busy), 1);
        chk("gap2_wr_en", 32'(fifo_wr_en), 0);
        @(negedge clk);
        chk("gap_done_busy", 32'(busy), 0);
        check_frames(0);

        // space gating: 4095-4080-8 = 7 < 16 blocks, 4000 leaves room
        wr_count = 12'd4080;
        req_len[CNT_W +: CNT_W] = 12'd16; req[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("gate_no_grant", 32'(grant), 0);
        chk("gate_busy", 32'(busy), 1);
        wr_count = 12'd4000;
        @(negedge clk);
        chk("gate_grant", 32'(grant), 32'h2);
        req[1] = 1'b0;
        send_bytes(1, 16, 16, 16, 0);
        check_frames(0);
        wr_count = '0;

        // contention: src0, src1, src0 in turn with no interleaving
        req_len = {12'd16, 12'd16};
        req = 2'b11;
        wait_grant(0);
        send_bytes(0, 16, 16, 16, 0);
        req[0] = 1'b1;
        wait_grant(1);
        send_bytes(1, 16, 16, 16, 0);
        wait_grant(0);
        send_bytes(0, 16, 16, 16, 0);
        check_frames(0);

        // backpressure: full toggles every 3 cycles
        req_len[CNT_W +: CNT_W] = 12'd16; req[1] = 1'b1;
        wait_grant(1);
        send_bytes(1, 16, 16, 16, 3);
        check_frames(0);

        // early last: 10 of 20 bytes
        req_len[0 +: CNT_W] = 12'd20; req[0] = 1'b1;
        wait_grant(0);
        send_bytes(0, 20, 10, 10, 0);
        check_frames(1);

        // missing last: 20 written, 5 drained
        req_len[CNT_W +: CNT_W] = 12'd20; req[1] = 1'b1;
        wait_grant(1);
        send_bytes(1, 20, 25, 25, 0);
        check_frames(1);

        // zero length: one err pulse, never granted
        req_len[CNT_W +: CNT_W] = 12'd0; req[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk("zero_no_grant", 32'(grant), 0);
        chk("zero_err_once", err_cnt, 1);
        req[1] = 1'b0;
        @(negedge clk);
        err_cnt = 0;

        // reset mid-frame after 4 bytes of 32
        req_len[0 +: CNT_W] = 12'd32; req[0] = 1'b1;
        wait_grant(0);
        send_bytes(0, 32, 4, 0, 0);
        src_valid[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_ready", 32'(src_ready), 0);
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 0);
        chk("mid_rst_din", 32'(fifo_din), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        src_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        wr_q.delete(); exp_q.delete(); err_cnt = 0;

        req_len[0 +: CNT_W] = 12'd8; req[0] = 1'b1;
        wait_grant(0);
        send_bytes(0, 8, 8, 8, 0);
        check_frames(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
